// File: rtl/alarm_controller.sv
// Intruder alarm controller: a registered Moore FSM with exit delay, entry delay,
// a timed siren, and a sticky record of the zones that tripped.
// The state register is visible directly on selsw so checkers can bind to it.
module alarm_controller #(
    parameter int EXIT_DELAY  = 8,
    parameter int ENTRY_DELAY = 8,
    parameter int SIREN_TIME  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic       disarm,
    input  logic [3:0] zone,
    output logic [2:0] selsw,
    output logic       siren,
    output logic       armed,
    output logic [3:0] zone_latched,
    output logic [1:0] zone_id
);

    typedef enum logic [2:0] {
        S_DISARMED   = 3'b000,
        S_EXIT_WAIT  = 3'b001,
        S_ARMED      = 3'b010,
        S_ENTRY_WAIT = 3'b011,
        S_ALARM      = 3'b100,
        S_SILENCED   = 3'b101
    } state_t;

    // Counter load values: a timed state lasts DELAY cycles because it exits
    // on the edge where the counter has reached zero.
    localparam logic [7:0] EXIT_LOAD  = 8'(EXIT_DELAY - 1);
    localparam logic [7:0] ENTRY_LOAD = 8'(ENTRY_DELAY - 1);
    localparam logic [7:0] SIREN_LOAD = 8'(SIREN_TIME - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] zone_latched_q, zone_latched_d;
    logic [1:0] zone_id_q, zone_id_d;
    logic [1:0] lowest_zone;

    // Index of the lowest-numbered active zone (only used when some zone is set).
    always_comb begin
        lowest_zone = 2'd0;
        casez (zone)
            4'b???1: lowest_zone = 2'd0;
            4'b??10: lowest_zone = 2'd1;
            4'b?100: lowest_zone = 2'd2;
            4'b1000: lowest_zone = 2'd3;
            default: lowest_zone = 2'd0;
        endcase
    end

    // Next-state, counter and zone-record logic; disarm overrides everything.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        zone_latched_d = zone_latched_q;
        zone_id_d      = zone_id_q;

        if (disarm) begin
            state_d        = S_DISARMED;
            cnt_d          = 8'd0;
            zone_latched_d = 4'b0000;
            zone_id_d      = 2'd0;
        end else begin
            case (state_q)
                S_DISARMED: begin
                    if (arm) begin
                        state_d = S_EXIT_WAIT;
                        cnt_d   = EXIT_LOAD;
                    end
                end
                S_EXIT_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        state_d = S_ARMED;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_ARMED: begin
                    if (zone != 4'b0000) begin
                        zone_latched_d = zone;
                        zone_id_d      = lowest_zone;
                        if (zone[3]) begin
                            state_d = S_ALARM;
                            cnt_d   = SIREN_LOAD;
                        end else begin
                            state_d = S_ENTRY_WAIT;
                            cnt_d   = ENTRY_LOAD;
                        end
                    end
                end
                S_ENTRY_WAIT: begin
                    zone_latched_d = zone_latched_q | zone;
                    if (zone[3] || (cnt_q == 8'd0)) begin
                        state_d = S_ALARM;
                        cnt_d   = SIREN_LOAD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_ALARM: begin
                    zone_latched_d = zone_latched_q | zone;
                    if (cnt_q == 8'd0) begin
                        state_d = S_SILENCED;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                S_SILENCED: begin
                    zone_latched_d = zone_latched_q | zone;
                    if (zone != 4'b0000) begin
                        state_d = S_ALARM;
                        cnt_d   = SIREN_LOAD;
                    end
                end
                default: begin
                    // Unused codes 110/111 recover to a clean disarmed state.
                    state_d        = S_DISARMED;
                    cnt_d          = 8'd0;
                    zone_latched_d = 4'b0000;
                    zone_id_d      = 2'd0;
                end
            endcase
        end
    end

    // State, counter and zone record registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_DISARMED;
            cnt_q          <= 8'd0;
            zone_latched_q <= 4'b0000;
            zone_id_q      <= 2'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            zone_latched_q <= zone_latched_d;
            zone_id_q      <= zone_id_d;
        end
    end

    // Outputs decode only registered state, never the inputs.
    always_comb begin
        selsw        = state_q;
        siren        = (state_q == S_ALARM);
        armed        = (state_q == S_ARMED) || (state_q == S_ENTRY_WAIT) ||
                       (state_q == S_ALARM) || (state_q == S_SILENCED);
        zone_latched = zone_latched_q;
        zone_id      = zone_id_q;
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Testbench for alarm_controller: directed scenarios with fixed expectations,
// then random traffic compared against a cycle-level behavioural model.
module tb_alarm_controller;

    localparam int EXIT_DELAY  = 4;
    localparam int ENTRY_DELAY = 3;
    localparam int SIREN_TIME  = 5;

    logic       clk;
    logic       reset;
    logic       arm;
    logic       disarm;
    logic [3:0] zone;
    logic [2:0] selsw;
    logic       siren;
    logic       armed;
    logic [3:0] zone_latched;
    logic [1:0] zone_id;

    int total = 0;
    int bad   = 0;

    logic [10:0] exp_q[$];

    // Behavioural model: state code, cycles spent so far in the current state,
    // zone record and first-trip id.
    int         m_state;
    int         m_ticks;
    logic [3:0] m_zl;
    logic [1:0] m_zid;
    logic       siren_seen;

    alarm_controller #(
        .EXIT_DELAY (EXIT_DELAY),
        .ENTRY_DELAY(ENTRY_DELAY),
        .SIREN_TIME (SIREN_TIME)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .disarm      (disarm),
        .zone        (zone),
        .selsw       (selsw),
        .siren       (siren),
        .armed       (armed),
        .zone_latched(zone_latched),
        .zone_id     (zone_id)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] lowest(input logic [3:0] z);
        for (int i = 0; i < 4; i++) begin
            if (z[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic enter(input int s);
        m_state = s;
        m_ticks = 1;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input logic a, input logic d, input logic [3:0] z, input logic r);
        if (r || d) begin
            m_state = 0;
            m_ticks = 0;
            m_zl    = 4'b0000;
            m_zid   = 2'd0;
        end else begin
            case (m_state)
                0: if (a) enter(1);
                1: if (m_ticks == EXIT_DELAY) enter(2); else m_ticks++;
                2: if (z != 4'b0000) begin
                    m_zl  = z;
                    m_zid = lowest(z);
                    if (z[3]) enter(4); else enter(3);
                end
                3: begin
                    m_zl = m_zl | z;
                    if (z[3] || m_ticks == ENTRY_DELAY) enter(4); else m_ticks++;
                end
                4: begin
                    m_zl = m_zl | z;
                    if (m_ticks == SIREN_TIME) enter(5); else m_ticks++;
                end
                5: begin
                    m_zl = m_zl | z;
                    if (z != 4'b0000) enter(4);
                end
                default: m_state = 0;
            endcase
        end
    endtask

    function automatic logic [10:0] model_vec();
        logic m_armed;
        m_armed = (m_state >= 2);
        return {3'(m_state), (m_state == 4), m_armed, m_zl, m_zid};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: compare DUT outputs against the oldest model expectation.
    task automatic sb_check();
        logic [10:0] expv;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            expv = exp_q.pop_front();
            check("model", {21'd0, selsw, siren, armed, zone_latched, zone_id}, {21'd0, expv});
        end
    endtask

    // Driver: apply inputs for one edge, advance the model, sample after the edge.
    task automatic step(input logic a, input logic d, input logic [3:0] z, input logic r);
        arm    = a;
        disarm = d;
        zone   = z;
        reset  = r;
        @(posedge clk);
        model_edge(a, d, z, r);
        exp_q.push_back(model_vec());
        #1;
        if (siren) siren_seen = 1'b1;
        sb_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    // Arm from DISARMED and wait out the exit delay.
    task automatic arm_up();
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        idle(EXIT_DELAY);
        check("armed_state", 32'(selsw), 32'd2);
    endtask

    initial begin
        arm = 1'b0; disarm = 1'b0; zone = 4'b0000; reset = 1'b1;
        m_state = 0; m_ticks = 0; m_zl = 4'b0000; m_zid = 2'd0;
        siren_seen = 1'b0;

        // Reset with arm and all zones active
        step(1'b1, 1'b0, 4'b1111, 1'b1);
        step(1'b1, 1'b0, 4'b1111, 1'b1);
        check("rst_selsw", 32'(selsw), 32'd0);
        check("rst_siren", 32'(siren), 32'd0);
        check("rst_armed", 32'(armed), 32'd0);
        check("rst_zl", 32'(zone_latched), 32'd0);
        check("rst_zid", 32'(zone_id), 32'd0);
        idle(1);

        // arm together with disarm stays disarmed
        step(1'b1, 1'b1, 4'b0000, 1'b0);
        check("arm_dis_selsw", 32'(selsw), 32'd0);

        // Arming: four cycles of EXIT_WAIT, zones ignored, then ARMED
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        check("exit_e1", 32'(selsw), 32'd1);
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 1'b0, 4'b0001, 1'b0);
            check("exit_en", 32'(selsw), 32'd1);
        end
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        check("exit_armed_selsw", 32'(selsw), 32'd2);
        check("exit_armed_armed", 32'(armed), 32'd1);
        check("exit_zl_clean", 32'(zone_latched), 32'd0);

        // Full alarm path
        step(1'b0, 1'b0, 4'b0110, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("entry_selsw", 32'(selsw), 32'd3);
            check("entry_zid", 32'(zone_id), 32'd1);
            check("entry_zl", 32'(zone_latched), 32'h6);
            step(1'b0, 1'b0, 4'b0000, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            check("alarm_selsw", 32'(selsw), 32'd4);
            check("alarm_siren", 32'(siren), 32'd1);
            step(1'b0, 1'b0, 4'b0000, 1'b0);
        end
        check("silenced_selsw", 32'(selsw), 32'd5);
        check("silenced_siren", 32'(siren), 32'd0);
        idle(2);
        check("silenced_hold", 32'(selsw), 32'd5);
        step(1'b0, 1'b0, 4'b0001, 1'b0);
        check("realarm_selsw", 32'(selsw), 32'd4);
        check("realarm_zl", 32'(zone_latched), 32'h7);
        check("realarm_zid", 32'(zone_id), 32'd1);

        // Disarm clears everything; panic zone from ARMED
        step(1'b0, 1'b1, 4'b1111, 1'b0);
        check("disarm_selsw", 32'(selsw), 32'd0);
        check("disarm_zl", 32'(zone_latched), 32'd0);
        arm_up();
        step(1'b0, 1'b0, 4'b1000, 1'b0);
        check("panic_selsw", 32'(selsw), 32'd4);
        check("panic_zid", 32'(zone_id), 32'd3);

        // Panic zone during ENTRY_WAIT skips the remaining delay
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        arm_up();
        step(1'b0, 1'b0, 4'b0010, 1'b0);
        check("entry2_selsw", 32'(selsw), 32'd3);
        step(1'b0, 1'b0, 4'b1000, 1'b0);
        check("entry_panic_selsw", 32'(selsw), 32'd4);
        check("entry_panic_zl", 32'(zone_latched), 32'hA);
        check("entry_panic_zid", 32'(zone_id), 32'd1);

        // Disarm during the second ENTRY_WAIT cycle: siren never sounds
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        arm_up();
        siren_seen = 1'b0;
        step(1'b0, 1'b0, 4'b0100, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        check("entry_c2_selsw", 32'(selsw), 32'd3);
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        check("entry_dis_selsw", 32'(selsw), 32'd0);
        check("entry_dis_zl", 32'(zone_latched), 32'd0);
        idle(3);
        check("entry_dis_no_siren", 32'(siren_seen), 32'd0);

        // Reset in ALARM cycle 2, then a normal re-arm
        arm_up();
        step(1'b0, 1'b0, 4'b1000, 1'b0);
        step(1'b0, 1'b0, 4'b0000, 1'b0);
        check("alarm_c2_siren", 32'(siren), 32'd1);
        step(1'b1, 1'b0, 4'b1111, 1'b1);
        check("mid_rst_selsw", 32'(selsw), 32'd0);
        check("mid_rst_siren", 32'(siren), 32'd0);
        check("mid_rst_zl", 32'(zone_latched), 32'd0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("rearm_exit", 32'(selsw), 32'd1);
            step(1'b0, 1'b0, 4'b0000, 1'b0);
        end
        check("rearm_armed", 32'(selsw), 32'd2);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic       r_a, r_d, r_r;
            logic [3:0] r_z;
            r_r = ($urandom_range(0, 149) == 0);
            r_d = ($urandom_range(0, 39) == 0);
            r_a = ($urandom_range(0, 3) == 0);
            r_z = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            step(r_a, r_d, r_z, r_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
